// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: RAM control bundle, arbiter
// state encoding and port indices.
package dmem;

  localparam int unsigned DMEM_AW = 8;
  localparam int unsigned DMEM_DW = 8;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } ArbState;

  // Control bundle presented to the single-port RAM.
  typedef struct packed {
    logic               en;
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
  } DMemCtrl;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data RAM.
// Port 0 is the core, port 1 the loader/debug master. A granted port may
// take a bounded lock for uninterrupted burst access.
module dmem_arbiter
  import dmem::*;
#(
  parameter int unsigned LOCK_MAX = 16,
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [1:0]    lock,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [DW-1:0] rdata,
  output DMemCtrl       dmem_ctrl,
  input  logic [DW-1:0] dmem_out
);

  localparam int unsigned CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  ArbState       state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]    rd_pend_q, rd_pend_d;
  logic [1:0]    gnt_c;
  logic          owner;
  logic          sel;

  // Round-robin pick: on a conflict the port that did not win last time wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] r, input logic l);
    if (r == 2'b11) return l ? 2'b01 : 2'b10;
    return r;
  endfunction

  // Next-state, grant and read-pending computation.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    gnt_c      = '0;
    owner      = PORT_CORE;
    unique case (state_q)
      IDLE: begin
        gnt_c = rr_pick(req, last_q);
        if (|gnt_c) begin
          owner  = gnt_c[1];
          last_d = owner;
          // A lock of length one is just the grant cycle, so no lock state.
          if (lock[owner] && (LOCK_MAX > 1)) begin
            state_d    = owner ? LOCK1 : LOCK0;
            lock_cnt_d = '0;
          end
        end
      end
      LOCK0, LOCK1: begin
        owner        = (state_q == LOCK1);
        gnt_c[owner] = req[owner];
        lock_cnt_d   = lock_cnt_q + 1'b1;
        if (!lock[owner] || (lock_cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          if (lock_cnt_q == CNT_LAST) last_d = owner;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) gnt_c = '0;
    rd_pend_d = gnt_c & ~we;
  end

  // RAM control driven straight from the grant; all-zero when idle.
  always_comb begin
    dmem_ctrl = '0;
    sel       = gnt_c[1];
    if (|gnt_c) begin
      dmem_ctrl.en    = 1'b1;
      dmem_ctrl.we    = we[sel];
      dmem_ctrl.addr  = sel ? DMEM_AW'(addr1) : DMEM_AW'(addr0);
      dmem_ctrl.wdata = sel ? DMEM_DW'(wdata1) : DMEM_DW'(wdata0);
    end
  end

  // State, round-robin pointer, lock counter and read-pending registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= PORT_LOAD;
      lock_cnt_q <= '0;
      rd_pend_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  // Read return is masked during reset so an in-flight read never surfaces.
  always_comb begin
    gnt    = gnt_c;
    rvalid = rd_pend_q & {2{~rst}};
    rdata  = (|rvalid) ? dmem_out : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with LOCK_MAX=4 and a behavioural RAM.
module tb_dmem_arbiter;
  import dmem::*;

  localparam int LMAX = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, we, lock;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic [7:0] dmem_out = '0;
  logic [1:0] gnt, rvalid;
  logic [7:0] rdata;
  DMemCtrl    dmem_ctrl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.LOCK_MAX(LMAX), .AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .dmem_ctrl(dmem_ctrl), .dmem_out(dmem_out)
  );

  // Behavioural synchronous RAM driven by the DUT's control bundle.
  logic [7:0] ram [256];
  initial for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
  always @(posedge clk) begin
    if (dmem_ctrl.en) begin
      if (dmem_ctrl.we) ram[dmem_ctrl.addr] <= dmem_ctrl.wdata;
      else              dmem_out <= ram[dmem_ctrl.addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lock owner with a count of locked cycles, round-robin
  // pointer, expected memory image and the read due next cycle.
  int         m_owner = -1;
  int         m_last  = 1;
  int         m_held  = 0;
  logic [1:0] m_pend  = '0;
  logic [7:0] m_pdata = '0;
  logic [7:0] m_mem [256];
  initial for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'h5A;

  always @(negedge clk) begin
    int         win;
    logic [1:0] eg;
    DMemCtrl    ec;
    if (rst) begin
      chk("rst_gnt", {30'b0, gnt}, 32'd0);
      chk("rst_en", {31'b0, dmem_ctrl.en}, 32'd0);
      chk("rst_rvalid", {30'b0, rvalid}, 32'd0);
      m_owner = -1; m_last = 1; m_held = 0; m_pend = '0;
    end else begin
      chk("rvalid", {30'b0, rvalid}, {30'b0, m_pend});
      if (m_pend != 2'b00) chk("rdata", {24'b0, rdata}, {24'b0, m_pdata});
      win = -1;
      if (m_owner >= 0) begin
        if (req[m_owner]) win = m_owner;
      end else if (req == 2'b11) win = 1 - m_last;
      else if (req[0]) win = 0;
      else if (req[1]) win = 1;
      eg = '0;
      ec = '0;
      if (win >= 0) begin
        eg[win]  = 1'b1;
        ec.en    = 1'b1;
        ec.we    = we[win];
        ec.addr  = (win == 1) ? addr1 : addr0;
        ec.wdata = (win == 1) ? wdata1 : wdata0;
      end
      chk("gnt", {30'b0, gnt}, {30'b0, eg});
      chk("dmem_ctrl", 32'(dmem_ctrl), 32'(ec));
      m_pend = '0;
      if (win >= 0) begin
        if (we[win]) m_mem[ec.addr] = ec.wdata;
        else begin
          m_pend[win] = 1'b1;
          m_pdata     = m_mem[ec.addr];
        end
      end
      if (m_owner >= 0) begin
        m_held++;
        if (m_held == LMAX) begin
          m_last  = m_owner;
          m_owner = -1;
        end else if (!lock[m_owner]) m_owner = -1;
      end else if (win >= 0) begin
        m_last = win;
        if (lock[win] && LMAX > 1) begin
          m_owner = win;
          m_held  = 0;
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [1:0] lk;
    rst = 1'b1; req = '0; we = '0; lock = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    @(negedge clk);
    lit("L_reset_gnt", {30'b0, gnt}, 32'h0);
    lit("L_reset_en", {31'b0, dmem_ctrl.en}, 32'h0);
    next();
    // Conflict after reset: port 0 first, then port 1, data in order.
    rst = 1'b0; req = 2'b11; addr0 = 8'h10; addr1 = 8'h20;
    @(negedge clk);
    lit("L_t1_gnt0", {30'b0, gnt}, 32'h1);
    lit("L_t1_addr0", {24'b0, dmem_ctrl.addr}, 32'h10);
    next(); req = 2'b10;
    @(negedge clk);
    lit("L_t1_gnt1", {30'b0, gnt}, 32'h2);
    lit("L_t1_rv0", {30'b0, rvalid}, 32'h1);
    lit("L_t1_rd0", {24'b0, rdata}, 32'h4A);
    next(); req = 2'b00;
    @(negedge clk);
    lit("L_t1_rv1", {30'b0, rvalid}, 32'h2);
    lit("L_t1_rd1", {24'b0, rdata}, 32'h7A);
    // Port 1 writes, port 0 reads the same address back.
    next(); req = 2'b10; we = 2'b10; addr1 = 8'h33; wdata1 = 8'hA5;
    @(negedge clk);
    lit("L_t2_wgnt", {30'b0, gnt}, 32'h2);
    next(); req = 2'b01; we = 2'b00; addr0 = 8'h33;
    @(negedge clk);
    lit("L_t2_rgnt", {30'b0, gnt}, 32'h1);
    next(); req = 2'b00;
    @(negedge clk);
    lit("L_t2_rv", {30'b0, rvalid}, 32'h1);
    lit("L_t2_rd", {24'b0, rdata}, 32'hA5);
    // Port 1 holds a lock against a waiting port 0 until forced release.
    next(); req = 2'b11; lock = 2'b10; addr0 = 8'h40; addr1 = 8'h41;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      lit("L_t3_lockgnt", {30'b0, gnt}, 32'h2);
      next();
    end
    @(negedge clk);
    lit("L_t3_release", {30'b0, gnt}, 32'h1);
    // Port 0 locks, drops the lock while granted, then port 1 gets in.
    next(); req = 2'b01; lock = 2'b01;
    @(negedge clk);
    lit("L_t4_entry", {30'b0, gnt}, 32'h1);
    next(); req = 2'b11;
    @(negedge clk);
    lit("L_t4_locked", {30'b0, gnt}, 32'h1);
    next(); lock = 2'b00;
    @(negedge clk);
    lit("L_t4_exit", {30'b0, gnt}, 32'h1);
    next();
    @(negedge clk);
    lit("L_t4_other", {30'b0, gnt}, 32'h2);
    // Reset pulsed right after a read grant swallows the read return.
    next(); req = 2'b01; addr0 = 8'h44;
    @(negedge clk);
    lit("L_t5_gnt", {30'b0, gnt}, 32'h1);
    next(); rst = 1'b1; req = 2'b00;
    @(negedge clk);
    lit("L_t5_rv_n1", {30'b0, rvalid}, 32'h0);
    next(); rst = 1'b0;
    @(negedge clk);
    lit("L_t5_rv_n2", {30'b0, rvalid}, 32'h0);
    next(); req = 2'b11;
    @(negedge clk);
    lit("L_t5_conflict", {30'b0, gnt}, 32'h1);
    next(); req = 2'b10;
    next(); req = 2'b00;
    next();
    // Idle bus.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      lit("L_t6_gnt", {30'b0, gnt}, 32'h0);
      lit("L_t6_en", {31'b0, dmem_ctrl.en}, 32'h0);
      lit("L_t6_rv", {30'b0, rvalid}, 32'h0);
      next();
    end
    // Mixed traffic with sticky lock requests and occasional reset.
    lk = 2'b00;
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      req = 2'($urandom);
      we  = 2'($urandom);
      if ($urandom_range(0, 5) == 0) lk[0] = ~lk[0];
      if ($urandom_range(0, 5) == 0) lk[1] = ~lk[1];
      lock   = lk;
      addr0  = 8'h30 + 8'($urandom_range(0, 7));
      addr1  = 8'h30 + 8'($urandom_range(0, 7));
      wdata0 = 8'($urandom);
      wdata1 = 8'($urandom);
      next();
    end
    rst = 1'b0; req = '0; we = '0; lock = '0;
    next();
    next();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
